fastserial_device_emu: RTL and testbench

FTDI-side endpoint of the fast opto-isolated serial link. It receives the host-driven FSCLK and FSDI, and drives FSDO and FSCTS exactly as the FT2232 channel B fast-serial port does. The block lets the FPGA-side fast-serial clock, receiver and transmitter be exercised in simulation, and in hardware as a pin-level loopback, without an FTDI part. It bridges to byte streams that carry a port bit on each side.

---
 rtl/fastserial_pkg.sv | 26 ++
 rtl/fastserial_device_emu_if.sv | 25 ++
 rtl/fastserial_emu_fifo.sv | 56 +++++
 rtl/fastserial_device_emu.sv | 209 ++++++++++++++++++++
 tb/tb_fastserial_device_emu.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fastserial_pkg.sv
// Shared types for the fast-serial device emulator: frame length, FSM state
// encodings and the {port, data} entry carried by both FIFOs.
package fastserial_pkg;

    localparam int FS_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DATA,
        R_PORT
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_SRC,
        T_STOP
    } tx_state_t;

    typedef struct packed {
        logic       port;
        logic [7:0] data;
    } fs_entry_t;

endpackage

// File: rtl/fastserial_device_emu_if.sv
// Byte-stream side of the fast-serial device emulator: RX and TX valid/ready
// streams with a port bit per entry, plus the RX drop pulse.
interface fastserial_device_emu_if;

    logic [7:0] o_rx_data;
    logic       o_rx_port;
    logic       o_rx_valid;
    logic       i_rx_ready;
    logic [7:0] i_tx_data;
    logic       i_tx_port;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic       o_rx_drop;

    modport master (
        output o_rx_data, o_rx_port, o_rx_valid, o_tx_ready, o_rx_drop,
        input  i_rx_ready, i_tx_data, i_tx_port, i_tx_valid
    );

    modport slave (
        input  o_rx_data, o_rx_port, o_rx_valid, o_tx_ready, o_rx_drop,
        output i_rx_ready, i_tx_data, i_tx_port, i_tx_valid
    );

endinterface

// File: rtl/fastserial_emu_fifo.sv
// Synchronous FIFO with the head entry presented straight from storage flops;
// a push into a full FIFO is accepted when a pop happens in the same cycle.
module fastserial_emu_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   full,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];
    assign level   = count;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fastserial_device_emu.sv
// FTDI-side fast-serial endpoint: samples FSDI on FSCLK rises, drives FSDO on
// falls, flow-controls with FSCTS. FASTSERIAL_EMU_LOOPBACK_EN echoes RX frames to TX.
module fastserial_device_emu
    import fastserial_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_fsclk,
    input  logic                           i_fsdi,
    output logic                           o_fsdo,
    output logic                           o_fscts,
    fastserial_device_emu_if.master        bus
);

    localparam int CNT_W = $clog2(FS_FRAME_BITS);
    localparam int LW    = $clog2(FIFO_DEPTH) + 1;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] di_sync;
    logic                   clk_prev;
    logic                   fs_rise;
    logic                   fs_fall;
    logic                   fs_di;

    rx_state_t  rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [7:0] rx_shift;
    logic       rx_drop_q;
    fs_entry_t  rx_wr;
    fs_entry_t  rx_head;
    logic       rx_full;
    logic       rx_empty;
    logic [LW-1:0] rx_level;
    logic [LW-1:0] rx_level_nx;
    logic       rx_start;
    logic       rx_push_req;
    logic       rx_accept;
    logic       rx_pop;
    logic       rx_idle_nx;
    logic       cts_nx;

    tx_state_t  tx_state;
    logic [CNT_W-1:0] tx_cnt;
    fs_entry_t  tx_cur;
    logic       tx_armed;
    fs_entry_t  tx_wr;
    fs_entry_t  tx_head;
    logic       tx_push;
    logic       tx_pop;
    logic       tx_full;
    logic       tx_empty;
    logic [LW-1:0] tx_level;

    // Both pins idle high; resetting the chain to 1 avoids a false start bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            clk_sync <= '1;
            di_sync  <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], i_fsclk};
            di_sync  <= {di_sync[SYNC_STAGES-2:0], i_fsdi};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fs_rise = clk_sync[SYNC_STAGES-1] & ~clk_prev;
    assign fs_fall = ~clk_sync[SYNC_STAGES-1] & clk_prev;
    assign fs_di   = di_sync[SYNC_STAGES-1];

    assign rx_start    = (rx_state == R_IDLE) && fs_rise && !fs_di;
    assign rx_push_req = (rx_state == R_PORT) && fs_rise;
    assign rx_accept   = rx_push_req && (!rx_full || rx_pop);
    assign rx_wr       = {fs_di, rx_shift};
    assign rx_level_nx = rx_level + LW'(rx_accept) - LW'(rx_pop);
    assign rx_idle_nx  = ((rx_state == R_IDLE) && !rx_start) || rx_push_req;
    assign cts_nx      = rx_idle_nx && (rx_level_nx != LW'(FIFO_DEPTH));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_state  <= R_IDLE;
            rx_cnt    <= '0;
            rx_shift  <= '0;
            rx_drop_q <= 1'b0;
            o_fscts   <= 1'b0;
        end else begin
            o_fscts   <= cts_nx;
            rx_drop_q <= rx_push_req && !rx_accept;
            case (rx_state)
                R_IDLE: if (rx_start) begin
                    rx_state <= R_DATA;
                    rx_cnt   <= '0;
                end
                R_DATA: if (fs_rise) begin
                    rx_shift <= {fs_di, rx_shift[7:1]};
                    rx_cnt   <= rx_cnt + CNT_W'(1);
                    if (rx_cnt == CNT_W'(7)) rx_state <= R_PORT;
                end
                R_PORT: if (fs_rise) rx_state <= R_IDLE;
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    fastserial_emu_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fs_entry_t))) u_rx_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .push    (rx_push_req),
        .wr_data (rx_wr),
        .full    (rx_full),
        .pop     (rx_pop),
        .rd_data (rx_head),
        .empty   (rx_empty),
        .level   (rx_level)
    );

    // A frame starts only after the line has been seen idle for one whole fall.
    assign tx_pop = (tx_state == T_IDLE) && fs_fall && tx_armed && !tx_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_cur   <= '0;
            tx_armed <= 1'b0;
            o_fsdo   <= 1'b1;
        end else if (fs_fall) begin
            case (tx_state)
                T_IDLE: begin
                    if (tx_pop) begin
                        o_fsdo   <= 1'b0;
                        tx_cur   <= tx_head;
                        tx_armed <= 1'b0;
                        tx_state <= T_START;
                    end else begin
                        tx_armed <= 1'b1;
                    end
                end
                T_START: begin
                    o_fsdo      <= tx_cur.data[0];
                    tx_cur.data <= tx_cur.data >> 1;
                    tx_cnt      <= CNT_W'(1);
                    tx_state    <= T_DATA;
                end
                T_DATA: begin
                    o_fsdo      <= tx_cur.data[0];
                    tx_cur.data <= tx_cur.data >> 1;
                    tx_cnt      <= tx_cnt + CNT_W'(1);
                    if (tx_cnt == CNT_W'(7)) tx_state <= T_SRC;
                end
                T_SRC: begin
                    o_fsdo   <= tx_cur.port;
                    tx_state <= T_STOP;
                end
                T_STOP: begin
                    o_fsdo   <= 1'b1;
                    tx_state <= T_IDLE;
                end
                default: begin
                    o_fsdo   <= 1'b1;
                    tx_state <= T_IDLE;
                end
            endcase
        end
    end

    fastserial_emu_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fs_entry_t))) u_tx_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .push    (tx_push),
        .wr_data (tx_wr),
        .full    (tx_full),
        .pop     (tx_pop),
        .rd_data (tx_head),
        .empty   (tx_empty),
        .level   (tx_level)
    );

`ifdef FASTSERIAL_EMU_LOOPBACK_EN
    logic unused_ext;
    assign unused_ext = ^{bus.i_tx_data, bus.i_tx_port, bus.i_tx_valid,
                          bus.i_rx_ready, tx_level};

    assign rx_pop         = !rx_empty && !tx_full;
    assign tx_push        = rx_pop;
    assign tx_wr          = rx_head;
    assign bus.o_rx_data  = '0;
    assign bus.o_rx_port  = 1'b0;
    assign bus.o_rx_valid = 1'b0;
    assign bus.o_tx_ready = 1'b0;
`else
    logic unused_tx_level;
    assign unused_tx_level = ^tx_level;

    assign rx_pop         = !rx_empty && bus.i_rx_ready;
    assign tx_push        = bus.i_tx_valid && !tx_full;
    assign tx_wr          = {bus.i_tx_port, bus.i_tx_data};
    assign bus.o_rx_data  = rx_head.data;
    assign bus.o_rx_port  = rx_head.port;
    assign bus.o_rx_valid = !rx_empty;
    assign bus.o_tx_ready = !tx_full;
`endif

    assign bus.o_rx_drop = rx_drop_q;

endmodule

// File: tb/tb_fastserial_device_emu.sv
// Directed bench for fastserial_device_emu: the bench plays the host, driving
// FSCLK at i_clk/8 and FSDI, and capturing FSDO once per bit time.
`timescale 1ns/1ps
module tb_fastserial_device_emu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fsclk = 1'b1;
    logic fsdi = 1'b1;
    logic fsdo;
    logic fscts;

    int n_cmp = 0;
    int n_bad = 0;
    int drop_count = 0;

    logic di_seq  [64];
    logic do_seq  [64];
    logic cts_seq [64];

    fastserial_device_emu_if bus ();

    fastserial_device_emu #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_fsclk (fsclk),
        .i_fsdi  (fsdi),
        .o_fsdo  (fsdo),
        .o_fscts (fscts),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.o_rx_drop === 1'b1) drop_count++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // One FSCLK period: fall + new FSDI, sample FSDO/FSCTS just before the rise.
    task automatic bit_period(input logic di, output logic dout, output logic cts);
        @(negedge clk);
        fsclk = 1'b0;
        fsdi  = di;
        repeat (4) @(negedge clk);
        dout  = fsdo;
        cts   = fscts;
        fsclk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_link(input int n);
        logic d, c;
        for (int i = 0; i < n; i++) begin
            bit_period(di_seq[i], d, c);
            do_seq[i]  = d;
            cts_seq[i] = c;
        end
    endtask

    task automatic clear_seq();
        for (int i = 0; i < 64; i++) begin
            di_seq[i]  = 1'b1;
            do_seq[i]  = 1'b1;
            cts_seq[i] = 1'b0;
        end
    endtask

    task automatic load_rx_frame(input int off, input logic [7:0] data, input logic port);
        di_seq[off] = 1'b0;
        for (int b = 0; b < 8; b++) di_seq[off + 1 + b] = data[b];
        di_seq[off + 9] = port;
    endtask

    function automatic void find_tx_frame(input int n, output int start,
                                          output logic [9:0] bits, output logic idle_after);
        start      = -1;
        bits       = '1;
        idle_after = 1'b0;
        for (int i = 0; i < n; i++)
            if (start < 0 && do_seq[i] === 1'b0) start = i;
        if (start >= 0 && start + 10 < n) begin
            for (int j = 0; j < 10; j++) bits[j] = do_seq[start + j];
            idle_after = 1'b1;
            for (int k = start + 10; k < n; k++)
                if (do_seq[k] !== 1'b1) idle_after = 1'b0;
        end
    endfunction

    task automatic push_tx(input logic [7:0] data, input logic port);
        @(negedge clk);
        bus.i_tx_data  = data;
        bus.i_tx_port  = port;
        bus.i_tx_valid = 1'b1;
        @(negedge clk);
        bus.i_tx_valid = 1'b0;
    endtask

    task automatic pop_rx(output logic v, output logic [7:0] d, output logic p);
        @(negedge clk);
        v = bus.o_rx_valid;
        d = bus.o_rx_data;
        p = bus.o_rx_port;
        bus.i_rx_ready = 1'b1;
        @(negedge clk);
        bus.i_rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (fsdo !== 1'b1) begin n_bad++; $display("FAIL reset_fsdo: got %b expected 1", fsdo); end
        n_cmp++; if (fscts !== 1'b0) begin n_bad++; $display("FAIL reset_fscts: got %b expected 0", fscts); end
        n_cmp++; if (bus.o_rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b expected 0", bus.o_rx_valid); end
        n_cmp++; if (bus.o_tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_tx_ready: got %b expected 1", bus.o_tx_ready); end
        n_cmp++; if (bus.o_rx_drop !== 1'b0) begin n_bad++; $display("FAIL reset_rx_drop: got %b expected 0", bus.o_rx_drop); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (fscts !== 1'b1) begin n_bad++; $display("FAIL release_fscts: got %b expected 1", fscts); end
        n_cmp++; if (fsdo !== 1'b1) begin n_bad++; $display("FAIL release_fsdo: got %b expected 1", fsdo); end
    endtask

    task automatic test_rx_frame();
        logic v, p;
        logic [7:0] d;
        int bad;
        clear_seq();
        load_rx_frame(1, 8'hA5, 1'b1);
        run_link(14);
        n_cmp++; if (cts_seq[1] !== 1'b1) begin n_bad++; $display("FAIL rx_cts_before: got %b expected 1", cts_seq[1]); end
        bad = 0;
        for (int i = 2; i <= 10; i++) if (cts_seq[i] !== 1'b0) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rx_cts_during: got %0d high samples expected 0", bad); end
        n_cmp++; if (cts_seq[11] !== 1'b1) begin n_bad++; $display("FAIL rx_cts_after: got %b expected 1", cts_seq[11]); end
        pop_rx(v, d, p);
        n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL rx_valid: got %b expected 1", v); end
        n_cmp++; if (d !== 8'hA5) begin n_bad++; $display("FAIL rx_data: got %h expected a5", d); end
        n_cmp++; if (p !== 1'b1) begin n_bad++; $display("FAIL rx_port: got %b expected 1", p); end
        @(negedge clk);
        n_cmp++; if (bus.o_rx_valid !== 1'b0) begin n_bad++; $display("FAIL rx_valid_after_pop: got %b expected 0", bus.o_rx_valid); end
    endtask

    task automatic test_tx_frame();
        int start;
        logic [9:0] bits;
        logic idle;
        push_tx(8'h3C, 1'b0);
        clear_seq();
        run_link(24);
        find_tx_frame(24, start, bits, idle);
        n_cmp++; if (start < 0) begin n_bad++; $display("FAIL tx_start: got no start bit expected one within 24 bit times"); end
        // Successive falls 0,0,0,1,1,1,1,0,0,0 listed from bit 0 upward.
        n_cmp++; if (bits !== 10'b0001111000) begin n_bad++; $display("FAIL tx_bits: got %b expected 0001111000", bits); end
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL tx_idle_after: got %b expected 1", idle); end
    endtask

    task automatic test_rx_full();
        logic [7:0] fd [4];
        logic       fp [4];
        logic v, p;
        logic [7:0] d;
        int drops_before;
        fd = '{8'h11, 8'h22, 8'h33, 8'h44};
        fp = '{1'b0, 1'b1, 1'b0, 1'b1};
        bus.i_rx_ready = 1'b0;
        clear_seq();
        for (int f = 0; f < 4; f++) load_rx_frame(1 + 11 * f, fd[f], fp[f]);
        run_link(46);
        n_cmp++; if (cts_seq[12] !== 1'b1) begin n_bad++; $display("FAIL full_cts_one_entry: got %b expected 1", cts_seq[12]); end
        n_cmp++; if (cts_seq[45] !== 1'b0) begin n_bad++; $display("FAIL full_cts_low: got %b expected 0", cts_seq[45]); end
        drops_before = drop_count;
        clear_seq();
        load_rx_frame(1, 8'h99, 1'b1);
        run_link(13);
        n_cmp++; if (drop_count != drops_before + 1) begin n_bad++; $display("FAIL full_drop_pulse: got %0d expected %0d", drop_count, drops_before + 1); end
        for (int f = 0; f < 4; f++) begin
            pop_rx(v, d, p);
            n_cmp++; if (v !== 1'b1 || d !== fd[f] || p !== fp[f]) begin
                n_bad++; $display("FAIL full_entry%0d: got v=%b %h/%b expected v=1 %h/%b", f, v, d, p, fd[f], fp[f]);
            end
        end
        @(negedge clk);
        n_cmp++; if (bus.o_rx_valid !== 1'b0) begin n_bad++; $display("FAIL full_drained: got %b expected 0", bus.o_rx_valid); end
        n_cmp++; if (fscts !== 1'b1) begin n_bad++; $display("FAIL full_cts_back: got %b expected 1", fscts); end
    endtask

    task automatic test_back_to_back();
        int start;
        logic [9:0] bits;
        logic idle, v, p;
        logic [7:0] d;
        push_tx(8'hFF, 1'b1);
        clear_seq();
        load_rx_frame(1, 8'h55, 1'b0);
        run_link(24);
        find_tx_frame(24, start, bits, idle);
        n_cmp++; if (bits !== 10'b1111111110) begin n_bad++; $display("FAIL dual_tx_bits: got %b expected 1111111110", bits); end
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL dual_tx_idle: got %b expected 1", idle); end
        pop_rx(v, d, p);
        n_cmp++; if (v !== 1'b1 || d !== 8'h55 || p !== 1'b0) begin
            n_bad++; $display("FAIL dual_rx: got v=%b %h/%b expected v=1 55/0", v, d, p);
        end
    endtask

    task automatic test_reset_mid_tx();
        int start;
        logic [9:0] bits;
        logic idle, s, c, done;
        // Leave an RX entry queued so the flush is visible.
        clear_seq();
        load_rx_frame(1, 8'h42, 1'b0);
        run_link(12);
        n_cmp++; if (bus.o_rx_valid !== 1'b1) begin n_bad++; $display("FAIL mid_rx_queued: got %b expected 1", bus.o_rx_valid); end
        push_tx(8'hE7, 1'b0);
        push_tx(8'h5A, 1'b1);
        start = -1;
        done  = 1'b0;
        s     = 1'b1;
        for (int i = 0; i < 30 && !done; i++) begin
            bit_period(1'b1, s, c);
            if (start < 0 && s === 1'b0) start = i;
            if (start >= 0 && i == start + 5) done = 1'b1;
        end
        // Bit time start+5 carries data bit 4 of 0xE7, which is 0.
        n_cmp++; if (!done || fsdo !== 1'b0) begin n_bad++; $display("FAIL mid_d4: got done=%b fsdo=%b expected done=1 fsdo=0", done, fsdo); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (fsdo !== 1'b1) begin n_bad++; $display("FAIL mid_rst_fsdo: got %b expected 1", fsdo); end
        n_cmp++; if (bus.o_rx_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rx_flush: got %b expected 0", bus.o_rx_valid); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (fscts !== 1'b1) begin n_bad++; $display("FAIL mid_release_cts: got %b expected 1", fscts); end
        push_tx(8'h81, 1'b1);
        clear_seq();
        run_link(30);
        find_tx_frame(30, start, bits, idle);
        n_cmp++; if (bits !== 10'b1100000010) begin n_bad++; $display("FAIL mid_next_bits: got %b expected 1100000010", bits); end
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL mid_no_stale_frame: got %b expected 1", idle); end
    endtask

    initial begin
        bus.i_rx_ready = 1'b0;
        bus.i_tx_data  = 8'h00;
        bus.i_tx_port  = 1'b0;
        bus.i_tx_valid = 1'b0;
        test_reset();
        test_rx_frame();
        test_tx_frame();
        test_rx_full();
        test_back_to_back();
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
